// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, field positions and the write-mask function
// used by both the commit path and the read-forwarding path.
package csr_file_pkg;

   typedef logic [11:0] csr_addr_t;

   localparam csr_addr_t CSR_MSTATUS   = 12'h300;
   localparam csr_addr_t CSR_MISA      = 12'h301;
   localparam csr_addr_t CSR_MIE       = 12'h304;
   localparam csr_addr_t CSR_MTVEC     = 12'h305;
   localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
   localparam csr_addr_t CSR_MEPC      = 12'h341;
   localparam csr_addr_t CSR_MCAUSE    = 12'h342;
   localparam csr_addr_t CSR_MTVAL     = 12'h343;
   localparam csr_addr_t CSR_MIP       = 12'h344;
   localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
   localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
   localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
   localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
   localparam csr_addr_t CSR_CYCLE     = 12'hC00;
   localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
   localparam csr_addr_t CSR_INSTRET   = 12'hC02;
   localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
   localparam csr_addr_t CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_WMASK = (32'd1 << MSTATUS_MIE) | (32'd1 << MSTATUS_MPIE);
   localparam logic [31:0] MIE_WMASK     = (32'd1 << MIE_MSIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);
   localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

   function automatic logic csr_writable(csr_addr_t addr);
      logic ok;
      ok = 1'b0;
      case (addr)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Value a write actually leaves in the register, including hardwired bits.
   function automatic logic [31:0] csr_wval(csr_addr_t addr, logic [31:0] wdata);
      logic [31:0] val;
      val = wdata;
      case (addr)
         CSR_MSTATUS:         val = (wdata & MSTATUS_WMASK) | MSTATUS_MPP;
         CSR_MIE:             val = wdata & MIE_WMASK;
         CSR_MTVEC, CSR_MEPC: val = {wdata[31:2], 2'b00};
         default:             val = wdata;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access bus: ID-stage read port plus the pipeline and clint write ports.
interface csr_file_if;
   import csr_file_pkg::*;

   csr_addr_t   raddr;
   logic [31:0] rdata;
   logic        ex_we;
   csr_addr_t   ex_waddr;
   logic [31:0] ex_wdata;
   logic        clint_we;
   csr_addr_t   clint_waddr;
   logic [31:0] clint_wdata;

   modport master (
      output raddr, ex_we, ex_waddr, ex_wdata, clint_we, clint_waddr, clint_wdata,
      input  rdata
   );

   modport slave (
      input  raddr, ex_we, ex_waddr, ex_wdata, clint_we, clint_waddr, clint_wdata,
      output rdata
   );
endinterface

// File: rtl/csr_file_counter64.sv
// 64-bit event counter with independently writable halves; a write to
// either half suppresses the increment and never carries into the other.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata_lo,
   input  logic [31:0] wdata_hi,
   output logic [63:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 64'd0;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata_lo;
         if (we_hi) count[63:32] <= wdata_hi;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: dual write ports (clint beats pipeline on the same
// address), forwarded combinational read port, mip sampling and counters.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   csr_file_if.slave   bus,
   input  logic        inst_retire,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic        irq_soft,
   output logic [31:0] csr_mtvec,
   output logic [31:0] csr_mepc,
   output logic [31:0] csr_mstatus,
   output logic        global_int_en
);

   logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval;
   logic [31:0] mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d;
   logic [2:0]  mip_q;
   logic [31:0] mip_val;
   logic [63:0] mcycle, minstret;
   logic        ex_hit, clint_hit;
   logic [31:0] ex_val, clint_val;

   assign clint_hit = bus.clint_we && csr_writable(bus.clint_waddr);
   assign ex_hit    = bus.ex_we && csr_writable(bus.ex_waddr) &&
                      !(clint_hit && (bus.clint_waddr == bus.ex_waddr));
   assign ex_val    = csr_wval(bus.ex_waddr, bus.ex_wdata);
   assign clint_val = csr_wval(bus.clint_waddr, bus.clint_wdata);

   // The clint case runs second so it wins whenever both target one register.
   always_comb begin
      mstatus_d  = mstatus;
      mie_d      = mie;
      mtvec_d    = mtvec;
      mscratch_d = mscratch;
      mepc_d     = mepc;
      mcause_d   = mcause;
      mtval_d    = mtval;
      if (ex_hit) begin
         case (bus.ex_waddr)
            CSR_MSTATUS:  mstatus_d  = ex_val;
            CSR_MIE:      mie_d      = ex_val;
            CSR_MTVEC:    mtvec_d    = ex_val;
            CSR_MSCRATCH: mscratch_d = ex_val;
            CSR_MEPC:     mepc_d     = ex_val;
            CSR_MCAUSE:   mcause_d   = ex_val;
            CSR_MTVAL:    mtval_d    = ex_val;
            default: ;
         endcase
      end
      if (clint_hit) begin
         case (bus.clint_waddr)
            CSR_MSTATUS:  mstatus_d  = clint_val;
            CSR_MIE:      mie_d      = clint_val;
            CSR_MTVEC:    mtvec_d    = clint_val;
            CSR_MSCRATCH: mscratch_d = clint_val;
            CSR_MEPC:     mepc_d     = clint_val;
            CSR_MCAUSE:   mcause_d   = clint_val;
            CSR_MTVAL:    mtval_d    = clint_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mstatus  <= MSTATUS_MPP;
         mie      <= 32'd0;
         mtvec    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch <= 32'd0;
         mepc     <= 32'd0;
         mcause   <= 32'd0;
         mtval    <= 32'd0;
         mip_q    <= 3'd0;
      end else begin
         mstatus  <= mstatus_d;
         mie      <= mie_d;
         mtvec    <= mtvec_d;
         mscratch <= mscratch_d;
         mepc     <= mepc_d;
         mcause   <= mcause_d;
         mtval    <= mtval_d;
         mip_q    <= {irq_ext, irq_timer, irq_soft};
      end
   end

   assign mip_val = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};

   logic cl_cyc_lo, cl_cyc_hi, cl_ins_lo, cl_ins_hi;
   logic ex_cyc_lo, ex_cyc_hi, ex_ins_lo, ex_ins_hi;

   assign cl_cyc_lo = clint_hit && (bus.clint_waddr == CSR_MCYCLE);
   assign cl_cyc_hi = clint_hit && (bus.clint_waddr == CSR_MCYCLEH);
   assign cl_ins_lo = clint_hit && (bus.clint_waddr == CSR_MINSTRET);
   assign cl_ins_hi = clint_hit && (bus.clint_waddr == CSR_MINSTRETH);
   assign ex_cyc_lo = ex_hit && (bus.ex_waddr == CSR_MCYCLE);
   assign ex_cyc_hi = ex_hit && (bus.ex_waddr == CSR_MCYCLEH);
   assign ex_ins_lo = ex_hit && (bus.ex_waddr == CSR_MINSTRET);
   assign ex_ins_hi = ex_hit && (bus.ex_waddr == CSR_MINSTRETH);

   csr_counter64 u_mcycle (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (1'b1),
      .we_lo    (cl_cyc_lo || ex_cyc_lo),
      .we_hi    (cl_cyc_hi || ex_cyc_hi),
      .wdata_lo (cl_cyc_lo ? clint_val : ex_val),
      .wdata_hi (cl_cyc_hi ? clint_val : ex_val),
      .count    (mcycle)
   );

   csr_counter64 u_minstret (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inst_retire),
      .we_lo    (cl_ins_lo || ex_ins_lo),
      .we_hi    (cl_ins_hi || ex_ins_hi),
      .wdata_lo (cl_ins_lo ? clint_val : ex_val),
      .wdata_hi (cl_ins_hi ? clint_val : ex_val),
      .count    (minstret)
   );

   always_comb begin
      bus.rdata = 32'd0;
      case (bus.raddr)
         CSR_MSTATUS:                 bus.rdata = mstatus;
         CSR_MISA:                    bus.rdata = MISA_VALUE;
         CSR_MIE:                     bus.rdata = mie;
         CSR_MTVEC:                   bus.rdata = mtvec;
         CSR_MSCRATCH:                bus.rdata = mscratch;
         CSR_MEPC:                    bus.rdata = mepc;
         CSR_MCAUSE:                  bus.rdata = mcause;
         CSR_MTVAL:                   bus.rdata = mtval;
         CSR_MIP:                     bus.rdata = mip_val;
         CSR_MCYCLE, CSR_CYCLE:       bus.rdata = mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:     bus.rdata = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:   bus.rdata = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: bus.rdata = minstret[63:32];
         CSR_MHARTID:                 bus.rdata = HART_ID;
         default:                     bus.rdata = 32'd0;
      endcase
      if (ex_hit && (bus.ex_waddr == bus.raddr))       bus.rdata = ex_val;
      if (clint_hit && (bus.clint_waddr == bus.raddr)) bus.rdata = clint_val;
   end

   assign csr_mtvec     = mtvec;
   assign csr_mepc      = mepc;
   assign csr_mstatus   = mstatus;
   assign global_int_en = mstatus[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, field masking, port priority,
// forwarding, counters, mip sampling and mid-run reset.
module tb_csr_file;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
   localparam logic [31:0] HART      = 32'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_retire, irq_ext, irq_timer, irq_soft;
   logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
   logic        global_int_en;
   int          tests = 0;
   int          failed = 0;

   csr_file_if bus ();

   csr_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .inst_retire   (inst_retire),
      .irq_ext       (irq_ext),
      .irq_timer     (irq_timer),
      .irq_soft      (irq_soft),
      .csr_mtvec     (csr_mtvec),
      .csr_mepc      (csr_mepc),
      .csr_mstatus   (csr_mstatus),
      .global_int_en (global_int_en)
   );

   always #5 clk = ~clk;

   task automatic idle();
      bus.ex_we = 1'b0;    bus.ex_waddr = 12'h0;    bus.ex_wdata = 32'h0;
      bus.clint_we = 1'b0; bus.clint_waddr = 12'h0; bus.clint_wdata = 32'h0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h301, 12'hF14, 12'hB00, 12'h344};
      logic [31:0] exp   [6] = '{32'h1800, 32'h1000, 32'h4000_0100, 32'd5, 32'h0, 32'h0};
      rst_n = 1'b0; idle(); bus.raddr = 12'h0;
      inst_retire = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.raddr = addrs[i]; #1;
         tests++;
         if (bus.rdata !== exp[i]) begin
            failed++; $display("FAIL reset_read[%h] got %h want %h", addrs[i], bus.rdata, exp[i]);
         end
      end
      tests++;
      if (global_int_en !== 1'b0 || csr_mstatus !== 32'h1800) begin
         failed++; $display("FAIL reset_outputs got gie=%b mstatus=%h want gie=0 mstatus=00001800", global_int_en, csr_mstatus);
      end
   endtask

   task automatic test_field_masks();
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h300; bus.ex_wdata = 32'hFFFF_FFFF;
      bus.raddr = 12'h300; #1;
      tests++;
      if (bus.rdata !== 32'h0000_1888) begin
         failed++; $display("FAIL mstatus_forward got %h want 00001888", bus.rdata);
      end
      step(); idle(); #1;
      tests++;
      if (bus.rdata !== 32'h0000_1888 || global_int_en !== 1'b1 || csr_mstatus !== 32'h0000_1888) begin
         failed++; $display("FAIL mstatus_commit got rdata=%h gie=%b out=%h want 00001888/1", bus.rdata, global_int_en, csr_mstatus);
      end
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h304; bus.ex_wdata = 32'hFFFF_FFFF;
      bus.clint_we = 1'b1; bus.clint_waddr = 12'h305; bus.clint_wdata = 32'h0000_2007;
      step(); idle(); bus.raddr = 12'h304; #1;
      tests++;
      if (bus.rdata !== 32'h0000_0888) begin
         failed++; $display("FAIL mie_mask got %h want 00000888", bus.rdata);
      end
      tests++;
      if (csr_mtvec !== 32'h0000_2004) begin
         failed++; $display("FAIL mtvec_mask got %h want 00002004", csr_mtvec);
      end
   endtask

   task automatic test_port_priority();
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h341; bus.ex_wdata = 32'h111;
      bus.clint_we = 1'b1; bus.clint_waddr = 12'h341; bus.clint_wdata = 32'h203;
      bus.raddr = 12'h341; #1;
      tests++;
      if (bus.rdata !== 32'h200) begin
         failed++; $display("FAIL same_addr_forward got %h want 00000200", bus.rdata);
      end
      step(); idle(); #1;
      tests++;
      if (bus.rdata !== 32'h200 || csr_mepc !== 32'h200) begin
         failed++; $display("FAIL same_addr_commit got rdata=%h mepc=%h want 00000200", bus.rdata, csr_mepc);
      end
   endtask

   task automatic test_both_commit();
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h340; bus.ex_wdata = 32'hA5;
      bus.clint_we = 1'b1; bus.clint_waddr = 12'h342; bus.clint_wdata = 32'hB;
      bus.raddr = 12'h342; #1;
      tests++;
      if (bus.rdata !== 32'hB) begin
         failed++; $display("FAIL clint_forward got %h want 0000000b", bus.rdata);
      end
      step(); idle(); bus.raddr = 12'h340; #1;
      tests++;
      if (bus.rdata !== 32'hA5) begin
         failed++; $display("FAIL dual_commit_mscratch got %h want 000000a5", bus.rdata);
      end
      bus.raddr = 12'h342; #1;
      tests++;
      if (bus.rdata !== 32'hB) begin
         failed++; $display("FAIL dual_commit_mcause got %h want 0000000b", bus.rdata);
      end
   endtask

   task automatic test_mcycle();
      bus.clint_we = 1'b1; bus.clint_waddr = 12'hB00; bus.clint_wdata = 32'hFFFF_FFFF;
      bus.ex_we = 1'b1; bus.ex_waddr = 12'hB80; bus.ex_wdata = 32'h0;
      step(); idle(); bus.raddr = 12'hB00; #1;
      tests++;
      if (bus.rdata !== 32'hFFFF_FFFF) begin
         failed++; $display("FAIL mcycle_preload_lo got %h want ffffffff", bus.rdata);
      end
      step(); bus.raddr = 12'hB80; #1;
      tests++;
      if (bus.rdata !== 32'h1) begin
         failed++; $display("FAIL mcycle_carry_hi got %h want 00000001", bus.rdata);
      end
      bus.raddr = 12'hC00; #1;
      tests++;
      if (bus.rdata !== 32'h0) begin
         failed++; $display("FAIL cycle_wrap_lo got %h want 00000000", bus.rdata);
      end
      bus.ex_we = 1'b1; bus.ex_waddr = 12'hB00; bus.ex_wdata = 32'h5;
      step(); idle(); bus.raddr = 12'hB00; #1;
      tests++;
      if (bus.rdata !== 32'h5) begin
         failed++; $display("FAIL mcycle_write got %h want 00000005", bus.rdata);
      end
      step();
      tests++;
      if (bus.rdata !== 32'h6) begin
         failed++; $display("FAIL mcycle_inc got %h want 00000006", bus.rdata);
      end
      bus.raddr = 12'hC80; #1;
      tests++;
      if (bus.rdata !== 32'h1) begin
         failed++; $display("FAIL mcycle_hi_hold got %h want 00000001", bus.rdata);
      end
   endtask

   task automatic test_minstret();
      inst_retire = 1'b1;
      bus.ex_we = 1'b1; bus.ex_waddr = 12'hB02; bus.ex_wdata = 32'd10;
      step(); idle(); bus.raddr = 12'hB02; #1;
      tests++;
      if (bus.rdata !== 32'd10) begin
         failed++; $display("FAIL minstret_write_beats_inc got %0d want 10", bus.rdata);
      end
      step(); inst_retire = 1'b0; #1;
      tests++;
      if (bus.rdata !== 32'd11) begin
         failed++; $display("FAIL minstret_inc got %0d want 11", bus.rdata);
      end
      step(); bus.raddr = 12'hC02; #1;
      tests++;
      if (bus.rdata !== 32'd11) begin
         failed++; $display("FAIL minstret_hold got %0d want 11", bus.rdata);
      end
   endtask

   task automatic test_mip_and_ro();
      irq_timer = 1'b1; bus.raddr = 12'h344; #1;
      tests++;
      if (bus.rdata !== 32'h0) begin
         failed++; $display("FAIL mip_latency got %h want 00000000", bus.rdata);
      end
      step(); irq_timer = 1'b0; #1;
      tests++;
      if (bus.rdata !== 32'h80) begin
         failed++; $display("FAIL mip_timer got %h want 00000080", bus.rdata);
      end
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h344; bus.ex_wdata = 32'hFFFF_FFFF; #1;
      tests++;
      if (bus.rdata !== 32'h80) begin
         failed++; $display("FAIL mip_ro_no_forward got %h want 00000080", bus.rdata);
      end
      step(); idle(); #1;
      tests++;
      if (bus.rdata !== 32'h0) begin
         failed++; $display("FAIL mip_ro_write got %h want 00000000", bus.rdata);
      end
      bus.ex_we = 1'b1; bus.ex_waddr = 12'hB00; bus.ex_wdata = 32'd100;
      step(); idle();
      bus.clint_we = 1'b1; bus.clint_waddr = 12'hC00; bus.clint_wdata = 32'h0;
      bus.raddr = 12'hC00; #1;
      tests++;
      if (bus.rdata !== 32'd100) begin
         failed++; $display("FAIL cycle_ro_forward got %0d want 100", bus.rdata);
      end
      step(); idle(); #1;
      tests++;
      if (bus.rdata !== 32'd101) begin
         failed++; $display("FAIL cycle_ro_write got %0d want 101", bus.rdata);
      end
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h7C0; bus.ex_wdata = 32'h1234;
      bus.raddr = 12'h7C0; #1;
      tests++;
      if (bus.rdata !== 32'h0) begin
         failed++; $display("FAIL unmapped_forward got %h want 00000000", bus.rdata);
      end
      step(); idle(); #1;
      tests++;
      if (bus.rdata !== 32'h0) begin
         failed++; $display("FAIL unmapped_read got %h want 00000000", bus.rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] addrs [6] = '{12'hB00, 12'hB80, 12'hB02, 12'h340, 12'h300, 12'h341};
      logic [31:0] exp   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1800, 32'h0};
      inst_retire = 1'b1;
      bus.ex_we = 1'b1; bus.ex_waddr = 12'h340; bus.ex_wdata = 32'h55;
      rst_n = 1'b0;
      step(); rst_n = 1'b1; idle(); inst_retire = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.raddr = addrs[i]; #1;
         tests++;
         if (bus.rdata !== exp[i]) begin
            failed++; $display("FAIL mid_reset_read[%h] got %h want %h", addrs[i], bus.rdata, exp[i]);
         end
      end
      tests++;
      if (global_int_en !== 1'b0 || csr_mepc !== 32'h0 || csr_mtvec !== 32'h1000) begin
         failed++; $display("FAIL mid_reset_outputs got gie=%b mepc=%h mtvec=%h want 0/00000000/00001000", global_int_en, csr_mepc, csr_mtvec);
      end
   endtask

   initial begin
      test_reset();
      step();
      test_field_masks();
      test_port_priority();
      test_both_commit();
      test_mcycle();
      test_minstret();
      test_mip_and_ro();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
